// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module   : pipeline_ctrl
// Purpose  : Load-use/branch stall-flush generation and debug halt/step/resume
//            run-control sequencer for the 5-stage RV32I pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipeline_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ResultSrcE,
  input  logic [4:0] RD_E,
  input  logic [4:0] RS1_D,
  input  logic [4:0] RS2_D,
  input  logic       PCSrcE,
  input  logic       halt_req,
  input  logic       step_req,
  input  logic       resume_req,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic       halted,
  output logic [1:0] ctrl_state
);

  localparam logic [1:0] c_RUN    = 2'd0;
  localparam logic [1:0] c_DRAIN  = 2'd1;
  localparam logic [1:0] c_HALTED = 2'd2;
  localparam logic [1:0] c_STEP   = 2'd3;

  localparam logic [2:0] c_DRAIN_LOAD = 3'(DRAIN_CYCLES);

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic [2:0] r_cnt;
  logic [2:0] w_next_cnt;
  logic       r_halted;

  logic       w_lw_stall;
  logic       w_br;
  logic       w_stall_f;
  logic       w_stall_d;
  logic       w_flush_d;
  logic       w_flush_e;

  assign w_lw_stall = ResultSrcE & (RD_E != 5'd0) &
                      ((RD_E == RS1_D) | (RD_E == RS2_D));
  assign w_br       = PCSrcE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= c_RUN;
      r_cnt    <= 3'd0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_next_cnt;
      r_halted <= (w_next_state == c_HALTED);
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      c_RUN: begin
        if (halt_req) begin
          w_next_state = c_DRAIN;
          w_next_cnt   = c_DRAIN_LOAD;
        end
      end
      c_DRAIN: begin
        // A redirect refetches a new instruction, so the drain restarts in full.
        if (w_br) begin
          w_next_cnt = c_DRAIN_LOAD;
        end else if (!w_lw_stall) begin
          if (r_cnt <= 3'd1) begin
            w_next_state = c_HALTED;
            w_next_cnt   = 3'd0;
          end else begin
            w_next_cnt = r_cnt - 3'd1;
          end
        end
      end
      c_HALTED: begin
        if (resume_req) begin
          w_next_state = c_RUN;
        end else if (step_req) begin
          w_next_state = c_STEP;
        end
      end
      c_STEP: begin
        w_next_state = c_DRAIN;
        w_next_cnt   = c_DRAIN_LOAD;
      end
      default: begin
        w_next_state = c_RUN;
        w_next_cnt   = 3'd0;
      end
    endcase
  end

  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    case (r_state)
      c_RUN: begin
        // The instruction in D is on the wrong path, so a branch beats the stall.
        w_stall_f = w_lw_stall & ~w_br;
        w_stall_d = w_lw_stall & ~w_br;
        w_flush_d = w_br;
        w_flush_e = w_lw_stall | w_br;
      end
      c_DRAIN, c_HALTED: begin
        if (w_br) begin
          w_flush_d = 1'b1;
          w_flush_e = 1'b1;
        end else if (w_lw_stall) begin
          w_stall_f = 1'b1;
          w_stall_d = 1'b1;
          w_flush_e = 1'b1;
        end else begin
          w_stall_f = 1'b1;
          w_flush_d = 1'b1;
        end
      end
      c_STEP: begin
        w_flush_e = w_br;
      end
      default: begin
        w_stall_f = 1'b0;
      end
    endcase
  end

  assign StallF     = rst & w_stall_f;
  assign StallD     = rst & w_stall_d;
  assign FlushD     = rst & w_flush_d;
  assign FlushE     = rst & w_flush_e;
  assign halted     = r_halted;
  assign ctrl_state = r_state;

endmodule

`default_nettype wire
